// File: rtl/mp_pkg.sv
// Shared definitions for the multi-precision add sequencer: slice width,
// maximum word count and FSM state encoding.
package mp_pkg;

    localparam int WORD_W    = 16;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca16_slice.sv
// Combinational 16-bit ripple-carry adder slice used once by mp_add_seq.
module rca16_slice
    import mp_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    // Bit-serial carry ripple from LSB to MSB
    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < WORD_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: computes a WORDS*16-bit sum one 16-bit
// word per cycle (LS word first) through a single ripple-carry slice, with
// the inter-word carry held in a register. Valid/ready on both sides.
// Optional subtract (A-B) is compiled in when MP_SUB_EN is defined.
module mp_add_seq
    import mp_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] A,
    input  logic [WORDS*WORD_W-1:0] B,
    input  logic                    Cin,
    input  logic                    Sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] S,
    output logic                    Cout,
    output logic                    Ovf
);

    localparam int         W    = WORDS * WORD_W;
    localparam logic [3:0] LAST = 4'(WORDS - 1);

    state_t              state;
    logic [3:0]          k;
    logic                carry;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;       // holds the effective B (inverted when subtracting)
    logic [W-1:0]        s_reg;
    logic                cout_reg;
    logic                ovf_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;

    logic [W-1:0]        beff_in;
    logic                cin_in;
    logic [WORD_W-1:0]   slice_a;
    logic [WORD_W-1:0]   slice_b;
    logic [WORD_W-1:0]   slice_s;
    logic                slice_cout;

`ifdef MP_SUB_EN
    // Subtraction is A + ~B + 1; Cin is ignored in that mode
    always_comb begin
        beff_in = Sub ? ~B : B;
        cin_in  = Sub ? 1'b1 : Cin;
    end
`else
    logic unused_sub;
    assign unused_sub = Sub;

    // Plain addition: operands pass through unchanged
    always_comb begin
        beff_in = B;
        cin_in  = Cin;
    end
`endif

    // Select word k of each operand register for the slice
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k == 4'(i)) begin
                slice_a = a_reg[i*WORD_W +: WORD_W];
                slice_b = b_reg[i*WORD_W +: WORD_W];
            end
        end
    end

    rca16_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Sequencer FSM with word counter, carry chain register and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            s_reg         <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= A;
                        b_reg        <= beff_in;
                        carry        <= cin_in;
                        k            <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (k == 4'(i)) begin
                            s_reg[i*WORD_W +: WORD_W] <= slice_s;
                        end
                    end
                    carry <= slice_cout;
                    if (k == LAST) begin
                        // Slice output here is the MS word, so its sign bit is S[W-1]
                        cout_reg      <= slice_cout;
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) &&
                                         (slice_s[WORD_W-1] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign S         = s_reg;
    assign Cout      = cout_reg;
    assign Ovf       = ovf_reg;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed testbench for mp_add_seq (WORDS=4) with a reference model of
// wide arithmetic and a per-cycle output checker.
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    logic busy = 1'b0;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    // Reference: whole-width arithmetic on the operands
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W:0]   sum;
        logic [W-1:0] beff;
        logic         c0;
        beff = b;
        c0   = cin;
`ifdef MP_SUB_EN
        if (sub) begin
            beff = ~b;
            c0   = 1'b1;
        end
`else
        if (sub) c0 = cin;
`endif
        sum = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c0};
        e.s = sum[W-1:0];
        e.c = sum[W];
        e.o = (a[W-1] == beff[W-1]) && (e.s[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
        end
    endtask

    // Track accepted operations and completed handshakes
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy <= 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                busy <= 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, Cin, Sub));
                busy <= 1'b1;
            end
        end
    end

    // Per-cycle output check against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) begin
                check("idle_out_valid", W'(out_valid), W'(1'b0));
                check("idle_in_ready", W'(in_ready), W'(1'b1));
            end else begin
                check("busy_in_ready", W'(in_ready), W'(1'b0));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("result_without_op", W'(1'b1), W'(1'b0));
                    end else begin
                        check("model_S", S, exp_q[0].s);
                        check("model_Cout", W'(Cout), W'(exp_q[0].c));
                        check("model_Ovf", W'(Ovf), W'(exp_q[0].o));
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", W'(1'b0), W'(1'b1));
        A = a; B = b; Cin = cin; Sub = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (!out_valid) check("done_timeout", W'(1'b0), W'(1'b1));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [W-1:0] s_hold;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_S", S, '0);
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_Cout", W'(Cout), W'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", W'(in_ready), W'(1'b1));

        // 1: carry out of word 0 into word 1, latency check
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done(lat);
        check("t1_latency", W'(lat), W'(4));
        check("t1_S", S, 64'h0000_0000_0001_0000);
        check("t1_Cout", W'(Cout), W'(1'b0));
        check("t1_Ovf", W'(Ovf), W'(1'b0));
        release_result();

        // 2: carry ripples through every word
        send({W{1'b1}}, '0, 1'b1, 1'b0);
        wait_done(lat);
        check("t2_S", S, '0);
        check("t2_Cout", W'(Cout), W'(1'b1));
        check("t2_Ovf", W'(Ovf), W'(1'b0));
        release_result();

        // 3: signed overflow
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done(lat);
        check("t3_S", S, 64'h8000_0000_0000_0000);
        check("t3_Cout", W'(Cout), W'(1'b0));
        check("t3_Ovf", W'(Ovf), W'(1'b1));
        release_result();

        // 4: consumer stall with producer pushing
        send(64'h3, 64'h4, 1'b0, 1'b0);
        wait_done(lat);
        A = 64'd100; B = 64'd200; Cin = 1'b0; Sub = 1'b0;
        in_valid = 1'b1;
        s_hold = S;
        check("t4_S", S, 64'h7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t4_hold_valid", W'(out_valid), W'(1'b1));
            check("t4_hold_ready", W'(in_ready), W'(1'b0));
            check("t4_hold_S", S, s_hold);
        end
        release_result();
        check("t4_idle_ready", W'(in_ready), W'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t4_captured", W'(in_ready), W'(1'b0));
        wait_done(lat);
        check("t4_second_lat", W'(lat), W'(4));
        check("t4_second_S", S, 64'd300);
        release_result();

        // 5: reset during the second RUN cycle
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_S", S, '0);
        check("t5_rst_valid", W'(out_valid), W'(1'b0));
        check("t5_rst_Cout", W'(Cout), W'(1'b0));
        check("t5_rst_Ovf", W'(Ovf), W'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_rel_ready", W'(in_ready), W'(1'b1));
        send(64'd5, 64'd7, 1'b0, 1'b0);
        wait_done(lat);
        check("t5_S", S, 64'd12);
        release_result();

        // 6: subtract request
        send(64'd5, 64'd7, 1'b0, 1'b1);
        wait_done(lat);
`ifdef MP_SUB_EN
        check("t6_S", S, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t6_Cout", W'(Cout), W'(1'b0));
`else
        check("t6_S", S, 64'd12);
        check("t6_Cout", W'(Cout), W'(1'b0));
`endif
        check("t6_Ovf", W'(Ovf), W'(1'b0));
        release_result();

        // Mixed carry pattern across word boundaries
        send(64'h8000_FFFF_0000_FFFF, 64'h8000_0001_FFFF_0001, 1'b1, 1'b0);
        wait_done(lat);
        check("t7_S", S, 64'h0001_0001_0000_0001);
        check("t7_Cout", W'(Cout), W'(1'b1));
        check("t7_Ovf", W'(Ovf), W'(1'b1));
        release_result();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
